// File: rtl/slc3_mem_pkg.sv
// Shared types and constants for the SLC-3 memory arbiter: FSM state and
// requester identifiers plus the default memory-mapped I/O word address.
package slc3_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MEM  = 2'd1,
        IO   = 2'd2,
        DONE = 2'd3
    } mem_state_t;

    typedef enum logic {
        CPU = 1'b0,
        LDR = 1'b1
    } mem_port_t;

    localparam logic [15:0] IO_ADDR_DEFAULT = 16'hFFFF;

endpackage

// File: rtl/slc3_mem_arbiter_rr_arb2.sv
// Two-requester round-robin arbiter: on a tie the port not served last wins;
// the last-served pointer only moves when the owner strobes update.
module rr_arb2
    import slc3_mem_pkg::*;
(
    input  logic clk,
    input  logic srst,
    input  logic req_cpu,
    input  logic req_ldr,
    input  logic update,
    input  logic upd_port,
    output logic gnt_valid,
    output logic gnt_port
);

    logic last_reg;

    // Pointer starts at LDR so the very first tie goes to the CPU.
    always_ff @(posedge clk) begin
        if (srst) begin
            last_reg <= LDR;
        end else if (update) begin
            last_reg <= upd_port;
        end
    end

    always_comb begin
        gnt_valid = req_cpu | req_ldr;
        gnt_port  = CPU;
        if (req_cpu && req_ldr) begin
            gnt_port = (last_reg == CPU) ? LDR : CPU;
        end else if (req_ldr) begin
            gnt_port = LDR;
        end
    end

endmodule

// File: rtl/slc3_mem_arbiter.sv
// Serialises CPU and loader traffic onto the shared SRAM and the switch/hex
// I/O word: one transaction at a time, round-robin, one-cycle acknowledge.
module slc3_mem_arbiter
    import slc3_mem_pkg::*;
#(
    parameter int                ADDR_W      = 16,
    parameter int                DATA_W      = 16,
    parameter int                WAIT_CYCLES = 2,
    parameter logic [ADDR_W-1:0] IO_ADDR     = ADDR_W'(IO_ADDR_DEFAULT)
) (
    input  logic              Clk,
    input  logic              Reset_ah,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    input  logic              ldr_req,
    input  logic              ldr_we,
    input  logic [ADDR_W-1:0] ldr_addr,
    input  logic [DATA_W-1:0] ldr_wdata,
    output logic [DATA_W-1:0] ldr_rdata,
    output logic              ldr_ack,
    output logic              mem_ce,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic [9:0]        SW,
    output logic [15:0]       hex_out
);

    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_MEM  = MEM;
    localparam logic [1:0] S_IO   = IO;
    localparam logic [1:0] S_DONE = DONE;
    localparam int         CNT_W  = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    logic [1:0]        state_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic              port_reg;
    logic              we_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [DATA_W-1:0] wdata_reg;
    logic [15:0]       hex_reg;

    logic              gnt_valid;
    logic              gnt_port;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              mem_last;
    logic              rd_load;
    logic [DATA_W-1:0] rd_data;
    logic [1:0]        ack_vec;

    rr_arb2 u_arb (
        .clk       (Clk),
        .srst      (Reset_ah),
        .req_cpu   (cpu_req),
        .req_ldr   (ldr_req),
        .update    (state_reg == S_DONE),
        .upd_port  (port_reg),
        .gnt_valid (gnt_valid),
        .gnt_port  (gnt_port)
    );

    always_comb begin
        sel_we    = (gnt_port == LDR) ? ldr_we    : cpu_we;
        sel_addr  = (gnt_port == LDR) ? ldr_addr  : cpu_addr;
        sel_wdata = (gnt_port == LDR) ? ldr_wdata : cpu_wdata;
    end

    assign mem_last = (state_reg == S_MEM) && (cnt_reg == CNT_W'(WAIT_CYCLES - 1));

    always_ff @(posedge Clk) begin
        if (Reset_ah) begin
            state_reg <= S_IDLE;
            cnt_reg   <= '0;
            port_reg  <= CPU;
            we_reg    <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            hex_reg   <= '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (gnt_valid) begin
                        port_reg  <= gnt_port;
                        we_reg    <= sel_we;
                        addr_reg  <= sel_addr;
                        wdata_reg <= sel_wdata;
                        cnt_reg   <= '0;
                        state_reg <= (sel_addr == IO_ADDR) ? S_IO : S_MEM;
                    end
                end
                S_MEM: begin
                    cnt_reg <= cnt_reg + 1'b1;
                    if (mem_last) begin
                        state_reg <= S_DONE;
                    end
                end
                S_IO: begin
                    if (we_reg) begin
                        hex_reg <= 16'(wdata_reg);
                    end
                    state_reg <= S_DONE;
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    // Read data is captured on the same edge that enters DONE, so it is
    // already valid while the acknowledge is high.
    assign rd_load = !we_reg && (mem_last || (state_reg == S_IO));
    assign rd_data = (state_reg == S_IO) ? DATA_W'(SW) : mem_rdata;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            logic [DATA_W-1:0] rdata_reg;

            always_ff @(posedge Clk) begin
                if (Reset_ah) begin
                    rdata_reg <= '0;
                end else if (rd_load && (port_reg == 1'(gi))) begin
                    rdata_reg <= rd_data;
                end
            end

            assign ack_vec[gi] = (state_reg == S_DONE) && (port_reg == 1'(gi));
        end
    endgenerate

    assign cpu_rdata = g_port[0].rdata_reg;
    assign ldr_rdata = g_port[1].rdata_reg;
    assign cpu_ack   = ack_vec[0];
    assign ldr_ack   = ack_vec[1];
    assign hex_out   = hex_reg;

    always_comb begin
        mem_ce    = (state_reg == S_MEM);
        mem_we    = mem_ce && we_reg;
        mem_addr  = mem_ce ? addr_reg : '0;
        mem_wdata = mem_we ? wdata_reg : '0;
    end

endmodule
